// File: rtl/cnn_conv1_mac_ctrl_if.sv
// ---------------------------------------------------------------------------
// cnn_conv1_mac_ctrl_if
// Block-level control bundle (ap_ctrl_hs handshake plus bias seed and result)
// between the conv1 loop nest and the MAC sequencer.
//
//   ap_start  : transaction request, level (loop nest -> sequencer)
//   bias      : signed accumulator seed, sampled on acceptance
//   ap_done   : one-cycle pulse, ap_return valid
//   ap_idle   : sequencer idle
//   ap_ready  : one-cycle pulse coincident with ap_done
//   ap_return : signed dot product plus bias, held until next ap_done
//
// Modports: master = loop nest side, slave = sequencer side.
// ---------------------------------------------------------------------------
interface cnn_conv1_mac_ctrl_if #(
    parameter int ACC_WIDTH = 32
);
    logic                        ap_start;
    logic signed [ACC_WIDTH-1:0] bias;
    logic                        ap_done;
    logic                        ap_idle;
    logic                        ap_ready;
    logic signed [ACC_WIDTH-1:0] ap_return;

    modport master (
        output ap_start,
        output bias,
        input  ap_done,
        input  ap_idle,
        input  ap_ready,
        input  ap_return
    );

    modport slave (
        input  ap_start,
        input  bias,
        output ap_done,
        output ap_idle,
        output ap_ready,
        output ap_return
    );
endinterface

// File: rtl/cnn_conv1_mac_ctrl.sv
// ---------------------------------------------------------------------------
// cnn_conv1_mac_ctrl
// Sequencer for the conv1 fixed-point MAC. Each transaction reads KLEN
// activation/weight pairs from two single-port BRAMs (1-cycle read latency),
// feeds them through an external combinational 14s x 6u -> 20s multiplier and
// accumulates the products onto a bias.
//
// Ports:
//   ap_clk, ap_rst          : clock (rising edge), synchronous active-high reset
//   ctrl (slave)            : ap_start/ap_done/ap_idle/ap_ready, bias, ap_return
//   x_address0/x_ce0/x_q0   : activation BRAM read port (x_q0 signed 14 bit)
//   w_address0/w_ce0/w_q0   : weight BRAM read port (w_q0 unsigned 6 bit)
//   mul_din0/mul_din1       : multiplier operands, straight copies of x_q0/w_q0
//   mul_dout                : signed 20-bit product back from the multiplier
//
// Timeline for a start sampled at edge 0: addresses 0..KLEN-1 are issued in
// cycles 1..KLEN, products are added in cycles 2..KLEN+1 (the last one in
// DRAIN), and ap_done is high in cycle KLEN+2.
// ---------------------------------------------------------------------------
module cnn_conv1_mac_ctrl #(
    parameter int KLEN       = 25,
    parameter int ADDR_WIDTH = 5,
    parameter int ACC_WIDTH  = 32
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst,
    cnn_conv1_mac_ctrl_if.slave          ctrl,
    output logic [ADDR_WIDTH-1:0]        x_address0,
    output logic                         x_ce0,
    input  logic signed [13:0]           x_q0,
    output logic [ADDR_WIDTH-1:0]        w_address0,
    output logic                         w_ce0,
    input  logic [5:0]                   w_q0,
    output logic signed [13:0]           mul_din0,
    output logic [5:0]                   mul_din1,
    input  logic signed [19:0]           mul_dout
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] IDX_LAST = ADDR_WIDTH'(KLEN - 1);

    state_t                      state_reg, state_next;
    logic [ADDR_WIDTH-1:0]       idx_reg, idx_next;
    logic                        ce_reg, ce_next;
    logic                        rd_valid_reg;
    logic signed [ACC_WIDTH-1:0] acc_reg;
    logic signed [ACC_WIDTH-1:0] ret_reg;
    logic                        accept;

    assign accept = (state_reg == S_IDLE) && ctrl.ap_start;

    // Next-state and next-address decode. ce/address are registered so the
    // BRAM sees clean flop outputs; ce_next is high exactly for RUN cycles.
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        ce_next    = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (ctrl.ap_start) begin
                    state_next = S_RUN;
                    idx_next   = '0;
                    ce_next    = 1'b1;
                end
            end
            S_RUN: begin
                if (idx_reg == IDX_LAST) begin
                    state_next = S_DRAIN;
                end else begin
                    idx_next = idx_reg + 1'b1;
                    ce_next  = 1'b1;
                end
            end
            S_DRAIN: begin
                state_next = S_DONE;
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_reg    <= S_IDLE;
            idx_reg      <= '0;
            ce_reg       <= 1'b0;
            rd_valid_reg <= 1'b0;
            acc_reg      <= '0;
            ret_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            ce_reg       <= ce_next;
            // BRAM data appears one cycle after the read enable.
            rd_valid_reg <= ce_reg;
            if (accept) begin
                acc_reg <= ctrl.bias;
            end else if (rd_valid_reg) begin
                acc_reg <= acc_reg + ACC_WIDTH'(mul_dout);
            end
            // Keep the result visible after DONE; acc is reseeded on the
            // next acceptance.
            if (state_reg == S_DONE) begin
                ret_reg <= acc_reg;
            end
        end
    end

    assign x_address0 = idx_reg;
    assign w_address0 = idx_reg;
    assign x_ce0      = ce_reg;
    assign w_ce0      = ce_reg;

    assign mul_din0   = x_q0;
    assign mul_din1   = w_q0;

    assign ctrl.ap_idle   = (state_reg == S_IDLE);
    assign ctrl.ap_done   = (state_reg == S_DONE);
    assign ctrl.ap_ready  = (state_reg == S_DONE);
    assign ctrl.ap_return = (state_reg == S_DONE) ? acc_reg : ret_reg;

endmodule
